// File: rtl/pc_adder_if.sv
// Fetch-stage PC increment bus: the current PC and enable in, the combinational
// and registered next-PC results plus status flags out.
interface pc_adder_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [WIDTH-1:0] PCin;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             valid_q;
  logic             misaligned;

  modport master (
    output en, PCin,
    input  out, carry, out_q, carry_q, valid_q, misaligned
  );

  modport slave (
    input  en, PCin,
    output out, carry, out_q, carry_q, valid_q, misaligned
  );
endinterface

// File: rtl/pc_adder.sv
// Sequential next-PC adder: out = PCin + STEP (mod 2^WIDTH) with carry, a registered copy,
// and an optional PC alignment flag enabled by defining PC_ADDER_ALIGN_CHECK_EN.
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_adder_if.slave   bus
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH:0] sum;

  // Extend by one bit so the wrap-around shows up as the carry.
  assign sum       = {1'b0, bus.PCin} + {1'b0, STEP_W};
  assign bus.out   = sum[WIDTH-1:0];
  assign bus.carry = sum[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q   <= '0;
      bus.carry_q <= 1'b0;
      bus.valid_q <= 1'b0;
    end else if (bus.en) begin
      bus.out_q   <= sum[WIDTH-1:0];
      bus.carry_q <= sum[WIDTH];
      bus.valid_q <= 1'b1;
    end
  end

`ifdef PC_ADDER_ALIGN_CHECK_EN
  assign bus.misaligned = |bus.PCin[1:0];
`else
  assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: combinational vector table, then registered
// behaviour checked through a scoreboard queue of expected loads.
module tb_pc_adder;
  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_out;
    logic        exp_carry;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        carry;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t        sb[$];
  logic [31:0] m_out_q;
  logic        m_carry_q;
  logic        m_valid_q;

  pc_adder_if #(.WIDTH(WIDTH)) bus ();

  pc_adder #(.WIDTH(WIDTH), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_mis(input logic [31:0] pc);
`ifdef PC_ADDER_ALIGN_CHECK_EN
    return |pc[1:0];
`else
    return pc[0] & 1'b0;
`endif
  endfunction

  task automatic check_regs(input string name);
    check({name, " out_q"},   bus.out_q,         m_out_q);
    check({name, " carry_q"}, {31'd0, bus.carry_q}, {31'd0, m_carry_q});
    check({name, " valid_q"}, {31'd0, bus.valid_q}, {31'd0, m_valid_q});
  endtask

  // Drive one cycle at the falling edge; loads are pushed to the scoreboard and
  // popped into the register model after the rising edge.
  task automatic cycle(input logic en, input logic [31:0] pc, input string name);
    logic [32:0] s;
    exp_t e;
    @(negedge clk);
    bus.en   = en;
    bus.PCin = pc;
    s = {1'b0, pc} + 33'd4;
    if (en) begin
      e.out   = s[31:0];
      e.carry = s[32];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en && rst_n) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: scoreboard empty got 1 expected entry", name);
      end else begin
        e = sb.pop_front();
        m_out_q   = e.out;
        m_carry_q = e.carry;
        m_valid_q = 1'b1;
      end
    end
    check_regs(name);
  endtask

  vec_t vecs[8];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_000A, 32'h0000_000E, 1'b0};
    vecs[2] = '{32'h0000_000E, 32'h0000_0012, 1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1};
    vecs[5] = '{32'h0000_0102, 32'h0000_0106, 1'b0};
    vecs[6] = '{32'h0000_0104, 32'h0000_0108, 1'b0};
    vecs[7] = '{32'h7FFF_FFFE, 32'h8000_0002, 1'b0};

    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.PCin = 32'h0;
    m_out_q   = 32'h0;
    m_carry_q = 1'b0;
    m_valid_q = 1'b0;
    #1;
    check_regs("reset");

    // Combinational path, exercised while still in reset.
    for (int i = 0; i < 8; i++) begin
      bus.PCin = vecs[i].pc;
      #1;
      check($sformatf("vec%0d out", i),   bus.out,             vecs[i].exp_out);
      check($sformatf("vec%0d carry", i), {31'd0, bus.carry},  {31'd0, vecs[i].exp_carry});
      check($sformatf("vec%0d mis", i),   {31'd0, bus.misaligned}, {31'd0, exp_mis(vecs[i].pc)});
    end

    // Clock with en=0 in reset, then release: nothing is loaded.
    cycle(1'b0, 32'h0000_0010, "rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0000_0020, "idle_after_rst");

    cycle(1'b1, 32'h0040_0000, "first_load");
    check("first_load direct", bus.out_q, 32'h0040_0004);

    // Hold with en=0 while the combinational output follows PCin.
    @(negedge clk);
    bus.en   = 1'b0;
    bus.PCin = 32'h0000_0100;
    #1;
    check("hold out comb", bus.out, 32'h0000_0104);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0000_0100, $sformatf("hold%0d", i));
    check("hold direct", bus.out_q, 32'h0040_0004);

    cycle(1'b1, 32'hFFFF_FFFE, "wrap_load");

    for (int i = 0; i < 10; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $sformatf("rand%0d", i));

    // Reset between edges clears everything without a clock.
    cycle(1'b1, 32'h0000_0300, "pre_rst_load");
    #2;
    rst_n = 1'b0;
    #1;
    m_out_q   = 32'h0;
    m_carry_q = 1'b0;
    m_valid_q = 1'b0;
    check_regs("mid_rst");

    // Release reset with en=1 ahead of the next edge: that edge loads.
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h0000_0200, "rst_release_load");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
